// File: rtl/instr_issue_unit.sv
// ============================================================================
// instr_issue_unit : fetches words from instruction memory and issues them over a valid/ready handshake
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module instr_issue_unit #(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_word,
  output logic              opcode_31,
  output logic [3:0]        funct_IF,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic [15:0]       issue_count
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_FETCH   = 3'd1;
  localparam logic [2:0] c_MEMWAIT = 3'd2;
  localparam logic [2:0] c_ISSUE   = 3'd3;
  localparam logic [2:0] c_HALT    = 3'd4;

  localparam logic [ADDR_W-1:0] c_PC_MAX    = {ADDR_W{1'b1}};
  localparam logic [15:0]       c_COUNT_MAX = 16'hFFFF;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_word_q, instr_word_d;
  logic [15:0]       issue_count_q, issue_count_d;
  logic              w_handshake;

  assign w_handshake = (state_q == c_ISSUE) && instr_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= c_IDLE;
      pc_q          <= '0;
      instr_word_q  <= '0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_word_q  <= instr_word_d;
      issue_count_q <= issue_count_d;
    end
  end

  // Next-state and datapath updates; redirect always wins over halt detection
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_word_d  = instr_word_q;
    issue_count_d = issue_count_q;
    case (state_q)
      c_IDLE, c_HALT: begin
        if (start) begin
          state_d       = c_FETCH;
          pc_d          = '0;
          issue_count_d = '0;
        end
      end
      c_FETCH: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else begin
          state_d = c_MEMWAIT;
        end
      end
      c_MEMWAIT: begin
        if (redirect_valid) begin
          // The returning word belongs to the abandoned path and is dropped.
          state_d = c_FETCH;
          pc_d    = redirect_pc;
        end else if (imem_rdata == HALT_WORD) begin
          state_d = c_HALT;
        end else begin
          state_d      = c_ISSUE;
          instr_word_d = imem_rdata;
        end
      end
      c_ISSUE: begin
        if (w_handshake && (issue_count_q != c_COUNT_MAX)) begin
          issue_count_d = issue_count_q + 16'd1;
        end
        if (redirect_valid) begin
          state_d = c_FETCH;
          pc_d    = redirect_pc;
        end else if (w_handshake) begin
          if (pc_q == c_PC_MAX) begin
            state_d = c_HALT;
          end else begin
            state_d = c_FETCH;
            pc_d    = pc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // State-decoded outputs
  always_comb begin
    imem_en     = 1'b0;
    instr_valid = 1'b0;
    busy        = 1'b0;
    halted      = 1'b0;
    case (state_q)
      c_FETCH: begin
        imem_en = 1'b1;
        busy    = 1'b1;
      end
      c_MEMWAIT: begin
        busy = 1'b1;
      end
      c_ISSUE: begin
        instr_valid = 1'b1;
        busy        = 1'b1;
      end
      c_HALT: begin
        halted = 1'b1;
      end
      default: begin
        imem_en = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_word  = instr_word_q;
  assign opcode_31   = instr_word_q[31];
  assign funct_IF    = instr_word_q[30:27];
  assign issue_count = issue_count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_issue_unit.sv
// ============================================================================
// tb_instr_issue_unit : self-checking bench with cycle table and issue scoreboard
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_instr_issue_unit;

  localparam logic [31:0] c_HALT_WORD = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, redirect_valid, instr_ready;
  logic [7:0]  redirect_pc;
  logic        imem_en, instr_valid, opcode_31, busy, halted;
  logic [7:0]  imem_addr, pc;
  logic [31:0] imem_rdata, instr_word;
  logic [3:0]  funct_IF;
  logic [15:0] issue_count;

  logic        start4, redirect_valid4, instr_ready4;
  logic [3:0]  redirect_pc4;
  logic        imem_en4, instr_valid4, opcode_31_4, busy4, halted4;
  logic [3:0]  imem_addr4, pc4;
  logic [31:0] imem_rdata4, instr_word4;
  logic [3:0]  funct_IF4;
  logic [15:0] issue_count4;

  logic [31:0] mem  [256];
  logic [31:0] mem4 [16];

  always #5 clk = ~clk;

  instr_issue_unit #(.ADDR_W(8), .HALT_WORD(c_HALT_WORD)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_word(instr_word),
    .opcode_31(opcode_31), .funct_IF(funct_IF), .pc(pc),
    .busy(busy), .halted(halted), .issue_count(issue_count)
  );

  instr_issue_unit #(.ADDR_W(4), .HALT_WORD(c_HALT_WORD)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
    .imem_en(imem_en4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
    .instr_valid(instr_valid4), .instr_ready(instr_ready4), .instr_word(instr_word4),
    .opcode_31(opcode_31_4), .funct_IF(funct_IF4), .pc(pc4),
    .busy(busy4), .halted(halted4), .issue_count(issue_count4)
  );

  // Synchronous-read memories: data one cycle after enable
  always @(posedge clk) if (imem_en)  imem_rdata  <= mem[imem_addr];
  always @(posedge clk) if (imem_en4) imem_rdata4 <= mem4[imem_addr4];

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic        start, ready;
    logic        en;
    logic [7:0]  addr;
    logic        valid, busy, halted;
    logic [7:0]  pc;
    logic [15:0] cnt;
  } vec_t;

  exp_t sbq[$];
  exp_t q4[$];
  vec_t tbl[11];

  int n_checks = 0;
  int n_fail   = 0;
  int fetches4 = 0;
  int zero4    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Observe handshakes just before the edge that completes them, then advance one cycle
  task automatic tick();
    exp_t e;
    if (rst_n && instr_valid && instr_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_issue_pc", 32'(pc), 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("issue_pc", 32'(pc), 32'(e.pc));
        chk("issue_word", instr_word, e.word);
        chk("opcode_31", 32'(opcode_31), 32'(e.word[31]));
        chk("funct_IF", 32'(funct_IF), 32'(e.word[30:27]));
      end
    end
    if (rst_n && instr_valid4 && instr_ready4) begin
      if (q4.size() == 0) begin
        chk("unexpected_issue4_pc", 32'(pc4), 32'hFFFF_FFFF);
      end else begin
        e = q4.pop_front();
        chk("issue4_pc", 32'(pc4), 32'(e.pc));
        chk("issue4_word", instr_word4, e.word);
      end
    end
    if (imem_en4) begin
      fetches4++;
      if (imem_addr4 == 4'd0) zero4++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int kind, input logic [7:0] a);
    case (kind)
      0:       return instr_valid;
      1:       return halted;
      2:       return imem_en && (imem_addr == a);
      default: return halted4;
    endcase
  endfunction

  task automatic wait_for(input int kind, input logic [7:0] a, input string name);
    for (int n = 0; n < 300; n++) begin
      if (cond(kind, a)) return;
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_%s: condition not reached, got timeout expected event", name);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic vec_t mk(input logic s, input logic r, input logic en, input logic [7:0] a,
                              input logic v, input logic b, input logic h, input logic [7:0] p,
                              input logic [15:0] c);
    vec_t t;
    t.start = s; t.ready = r; t.en = en; t.addr = a;
    t.valid = v; t.busy = b; t.halted = h; t.pc = p; t.cnt = c;
    return t;
  endfunction

  initial begin
    int last_rise;
    int seen;
    logic prev_valid;

    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 16'd1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 16'd1);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 8'h01, 16'd1);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h02, 16'd2);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 8'h02, 16'd2);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 8'h02, 16'd2);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1, 8'h02, 16'd2);

    for (int i = 0; i < 256; i++) mem[i] = 32'h0700_0000 | i;
    for (int i = 0; i < 16; i++)  mem4[i] = 32'h4000_0000 | i;

    rst_n = 1'b0;
    start = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b0;
    start4 = 1'b0; redirect_valid4 = 1'b0; redirect_pc4 = 4'h0; instr_ready4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(issue_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic program: two issues then HALT_WORD
    mem[0] = 32'h8800_0001; mem[1] = 32'h1000_0002; mem[2] = c_HALT_WORD;
    sbq.push_back('{8'h00, 32'h8800_0001});
    sbq.push_back('{8'h01, 32'h1000_0002});
    last_rise = -1;
    prev_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start;
      instr_ready = tbl[i].ready;
      chk($sformatf("t%0d_imem_en", i), 32'(imem_en), 32'(tbl[i].en));
      if (tbl[i].en) chk($sformatf("t%0d_imem_addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("t%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
      chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("t%0d_halted", i), 32'(halted), 32'(tbl[i].halted));
      chk($sformatf("t%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      chk($sformatf("t%0d_count", i), 32'(issue_count), 32'(tbl[i].cnt));
      if (instr_valid && !prev_valid) begin
        if (last_rise >= 0) chk("valid_rise_gap", 32'(i - last_rise), 32'd3);
        last_rise = i;
      end
      prev_valid = instr_valid;
      tick();
    end
    start = 1'b0;

    // Backpressure: five stalled cycles, one count on release
    mem[0] = 32'h1234_5678; mem[1] = c_HALT_WORD;
    sbq.push_back('{8'h00, 32'h1234_5678});
    instr_ready = 1'b0;
    pulse_start();
    wait_for(0, 8'h00, "bp_valid");
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(instr_valid), 32'd1);
      chk("bp_word", instr_word, 32'h1234_5678);
      chk("bp_pc", 32'(pc), 32'd0);
      chk("bp_count", 32'(issue_count), 32'd0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    chk("bp_count_after", 32'(issue_count), 32'd1);
    wait_for(1, 8'h00, "bp_halt");
    chk("bp_count_final", 32'(issue_count), 32'd1);

    // Redirect while in MEMWAIT at pc 1: word 1 never issues
    mem[0] = 32'h0A00_0000; mem[1] = 32'h0B00_0000;
    mem[8'h20] = 32'h0C00_0020; mem[8'h21] = c_HALT_WORD;
    sbq.push_back('{8'h00, 32'h0A00_0000});
    sbq.push_back('{8'h20, 32'h0C00_0020});
    pulse_start();
    wait_for(2, 8'h01, "rd_fetch1");
    tick();
    chk("rd_memwait_en", 32'(imem_en), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect_valid = 1'b0;
    chk("rd_next_en", 32'(imem_en), 32'd1);
    chk("rd_next_addr", 32'(imem_addr), 32'h20);
    chk("rd_next_valid", 32'(instr_valid), 32'd0);
    wait_for(1, 8'h00, "rd_halt");
    chk("rd_count", 32'(issue_count), 32'd2);

    // Redirect in ISSUE: first without handshake (dropped), then with one (counted)
    mem[0] = 32'h1100_0000; mem[8'h10] = 32'h2200_0010;
    mem[8'h11] = 32'h3300_0011; mem[8'h30] = c_HALT_WORD;
    sbq.push_back('{8'h10, 32'h2200_0010});
    instr_ready = 1'b0;
    pulse_start();
    wait_for(0, 8'h00, "ri_valid0");
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect_valid = 1'b0;
    chk("ri_drop_count", 32'(issue_count), 32'd0);
    chk("ri_drop_pc", 32'(pc), 32'h10);
    chk("ri_drop_en", 32'(imem_en), 32'd1);
    wait_for(0, 8'h00, "ri_valid1");
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 8'h30;
    tick();
    redirect_valid = 1'b0;
    chk("ri_hs_count", 32'(issue_count), 32'd1);
    chk("ri_hs_pc", 32'(pc), 32'h30);
    chk("ri_hs_en", 32'(imem_en), 32'd1);
    wait_for(1, 8'h00, "ri_halt");
    chk("ri_count_final", 32'(issue_count), 32'd1);

    // End of memory on the 4-bit instance: 16 issues, no wrap
    for (int i = 0; i < 16; i++) q4.push_back('{8'(i), 32'h4000_0000 | i});
    fetches4 = 0;
    zero4 = 0;
    instr_ready4 = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    wait_for(3, 8'h00, "eom_halt");
    chk("eom_count", 32'(issue_count4), 32'd16);
    chk("eom_pc", 32'(pc4), 32'd15);
    chk("eom_fetches", 32'(fetches4), 32'd16);
    chk("eom_addr0_fetches", 32'(zero4), 32'd1);
    chk("eom_queue_left", 32'(q4.size()), 32'd0);

    // Asynchronous reset while in MEMWAIT
    mem[0] = 32'h5500_0000; mem[1] = 32'h6600_0001; mem[2] = c_HALT_WORD;
    sbq.push_back('{8'h00, 32'h5500_0000});
    instr_ready = 1'b1;
    pulse_start();
    wait_for(2, 8'h01, "ar_fetch1");
    tick();
    chk("ar_pre_pc", 32'(pc), 32'd1);
    chk("ar_pre_count", 32'(issue_count), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_imem_en", 32'(imem_en), 32'd0);
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_halted", 32'(halted), 32'd0);
    chk("ar_pc", 32'(pc), 32'd0);
    chk("ar_word", instr_word, 32'd0);
    chk("ar_count", 32'(issue_count), 32'd0);
    chk("ar_halted4", 32'(halted4), 32'd0);
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (instr_valid || busy || imem_en) seen++;
    end
    chk("ar_idle_after_release", 32'(seen), 32'd0);
    chk("sb_queue_left", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_issue_unit.md
INSTR_ISSUE_UNIT -- requirements
Module: instr_issue_unit

Interface
REQ-001 Parameter ADDR_W, default 8: instruction memory word-address width.
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF: instruction word that stops issue.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; begins fetching at address 0.
REQ-006 redirect_valid  input  1  control-flow redirect request.
REQ-007 redirect_pc  input  ADDR_W  redirect target word address.
REQ-008 imem_en  output  1  instruction memory read enable.
REQ-009 imem_addr  output  ADDR_W  instruction memory word address.
REQ-010 imem_rdata  input  32  read data, valid exactly one cycle after imem_en.
REQ-011 instr_valid  output  1  issued instruction available.
REQ-012 instr_ready  input  1  downstream control unit accepts the instruction.
REQ-013 instr_word  output  32  registered instruction word.
REQ-014 opcode_31  output  1  instr_word[31].
REQ-015 funct_IF  output  4  instr_word[30:27].
REQ-016 pc  output  ADDR_W  address of the instruction in flight or issued.
REQ-017 busy  output  1  high in FETCH, MEMWAIT and ISSUE.
REQ-018 halted  output  1  high in HALT.
REQ-019 issue_count  output  16  number of completed handshakes, saturating at 16'hFFFF.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, MEMWAIT, ISSUE and HALT.
REQ-021 In IDLE, start=1 SHALL set pc=0, clear issue_count and move to FETCH; all other inputs are ignored.
REQ-022 In FETCH the unit SHALL drive imem_en=1 with imem_addr=pc for exactly one cycle, then enter MEMWAIT.
REQ-023 imem_en SHALL be 0 in every state other than FETCH.
REQ-024 In MEMWAIT, imem_rdata==HALT_WORD SHALL move the FSM to HALT without asserting instr_valid.
REQ-025 In MEMWAIT, any other imem_rdata SHALL be registered into instr_word and the FSM SHALL enter ISSUE.
REQ-026 instr_valid SHALL equal (state==ISSUE); instr_word, pc, opcode_31 and funct_IF SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-027 A handshake SHALL occur when instr_valid=1 and instr_ready=1; it increments issue_count (saturating).
REQ-028 On a handshake without redirect: pc==2^ADDR_W-1 SHALL move the FSM to HALT (no wrap); otherwise pc SHALL become pc+1 and the FSM SHALL enter FETCH.
REQ-029 Minimum issue latency SHALL be 3 cycles per instruction: FETCH, MEMWAIT, ISSUE.
REQ-030 redirect_valid=1 in FETCH, MEMWAIT or ISSUE SHALL set pc=redirect_pc and move the FSM to FETCH on the next edge.
REQ-031 Memory data returning for an instruction abandoned in MEMWAIT by a redirect SHALL be discarded.
REQ-032 In ISSUE, redirect combined with a handshake SHALL count the handshake; redirect without a handshake SHALL drop the instruction uncounted.
REQ-033 Redirect SHALL take priority over HALT_WORD detection and the end-of-memory halt.
REQ-034 redirect_valid SHALL be ignored in IDLE and HALT.
REQ-035 start SHALL be ignored in every state except IDLE and HALT.
REQ-036 In HALT, start=1 SHALL behave as in IDLE (pc=0, count cleared, enter FETCH).

Reset
REQ-037 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, pc=0, instr_word=0, issue_count=0, imem_en=0, instr_valid=0, busy=0 and halted=0.
REQ-038 Reset asserted mid-operation SHALL abandon any in-flight fetch; after release, no instr_valid SHALL assert until a new start.

Verification
REQ-039 Memory words 0..2 = 32'h8800_0001, 32'h1000_0002, HALT_WORD; start; instr_ready=1 -> two issues at pc 0 and 1; first with opcode_31=1 and funct_IF=4'h1; halted=1; issue_count=2; 3 cycles between instr_valid rises.
REQ-040 Backpressure: hold instr_ready=0 for 5 cycles in ISSUE -> instr_valid, instr_word and pc stay constant; exactly one count after instr_ready=1.
REQ-041 Redirect: assert redirect_valid with redirect_pc=8'h20 during MEMWAIT at pc=1 -> word 1 is never issued; next imem_addr=8'h20.
REQ-042 Redirect and handshake in the same ISSUE cycle -> issue_count increments by 1; pc becomes the target.
REQ-043 End of memory: ADDR_W=4, no HALT_WORD in memory -> 16 issues (pc 0..15), then HALT; imem_addr never wraps to 0.
REQ-044 Assert rst_n=0 asynchronously between edges while in MEMWAIT -> all outputs reach reset values before the next edge; no issue occurs after release until start.
